// File: rtl/range_mask_pkg.sv
// Shared definitions for the range mask generator.
//   mode_e : request mode encoding (THERMO, RANGE, WRAP, ALL)
//   MODE_W : width of the mode field
package range_mask_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_THERMO = 2'b00,
        MODE_RANGE  = 2'b01,
        MODE_WRAP   = 2'b10,
        MODE_ALL    = 2'b11
    } mode_e;

endpackage

// File: rtl/range_mask_gen_thermo_decode.sv
// Combinational thermometer decoder: o_out[i] = (i < i_in).
// Ports:
//   i_in  [N:0]      threshold, values >= 2^N give all ones
//   o_out [2^N-1:0]  thermometer mask
module thermo_decode #(
    parameter int unsigned N = 6
) (
    input  logic [N:0]        i_in,
    output logic [(2**N)-1:0] o_out
);

    localparam int unsigned M = 2 ** N;
    localparam int unsigned W = N + 1;

    // Index i always fits in N+1 bits, so the compare saturates naturally.
    for (genvar i = 0; i < M; i++) begin : g_bit
        assign o_out[i] = (W'(i) < i_in);
    end

endmodule

// File: rtl/range_mask_gen.sv
// Two-stage pipelined contiguous-mask generator with valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake (in_ready is combinational from out_ready)
//   in_lo [N-1:0]         range start (inclusive)
//   in_hi [N:0]           range end (exclusive), 2^N = to top
//   in_mode [1:0]         THERMO / RANGE / WRAP / ALL
//   out_valid/out_ready   result handshake
//   out_mask [2^N-1:0]    generated mask
//   out_count [N:0]       mask population (only when RANGE_MASK_COUNT_EN is defined, else 0)
// Optional feature macro: RANGE_MASK_COUNT_EN
module range_mask_gen
    import range_mask_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_lo,
    input  logic [N:0]          in_hi,
    input  logic [MODE_W-1:0]   in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(2**N)-1:0]   out_mask,
    output logic [N:0]          out_count
);

    localparam int unsigned M = 2 ** N;
    localparam int unsigned W = N + 1;

    logic          r_s1_valid;
    logic [N-1:0]  r_s1_lo;
    logic [N:0]    r_s1_hi;
    mode_e         r_s1_mode;
    logic [M-1:0]  r_s1_t_hi;
    logic [M-1:0]  r_s1_t_lo;

    logic          r_s2_valid;
    logic [M-1:0]  r_s2_mask;

    logic          w_s2_adv;
    logic          w_s1_adv;
    logic [M-1:0]  w_t_hi;
    logic [M-1:0]  w_t_lo;
    logic          w_lo_lt_hi;
    logic [M-1:0]  w_mask;

    // Handshake: a stage moves when it is empty or the one downstream moves.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    thermo_decode #(.N(N)) u_thermo_hi (
        .i_in  (in_hi),
        .o_out (w_t_hi)
    );

    thermo_decode #(.N(N)) u_thermo_lo (
        .i_in  ({1'b0, in_lo}),
        .o_out (w_t_lo)
    );

    // Stage 1: capture request and both thermometer codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_hi    <= '0;
            r_s1_mode  <= MODE_THERMO;
            r_s1_t_hi  <= '0;
            r_s1_t_lo  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_lo   <= in_lo;
                r_s1_hi   <= in_hi;
                r_s1_mode <= mode_e'(in_mode);
                r_s1_t_hi <= w_t_hi;
                r_s1_t_lo <= w_t_lo;
            end
        end
    end

    assign w_lo_lt_hi = ({1'b0, r_s1_lo} < r_s1_hi);

    // Mask select; for lo>=hi the RANGE term is already zero since t_hi is within t_lo.
    always_comb begin
        w_mask = '0;
        unique case (r_s1_mode)
            MODE_THERMO: w_mask = r_s1_t_hi;
            MODE_RANGE:  w_mask = r_s1_t_hi & ~r_s1_t_lo;
            MODE_WRAP:   w_mask = w_lo_lt_hi ? (r_s1_t_hi & ~r_s1_t_lo)
                                             : (r_s1_t_hi | ~r_s1_t_lo);
            MODE_ALL:    w_mask = '1;
            default:     w_mask = '0;
        endcase
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mask  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mask <= w_mask;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_mask  = r_s2_mask;

`ifdef RANGE_MASK_COUNT_EN
    logic [N:0] r_s2_count;
    logic [N:0] w_count;

    // Count from the bounds directly; wrap case is (2^N - lo) + hi.
    always_comb begin
        w_count = '0;
        unique case (r_s1_mode)
            MODE_THERMO: w_count = r_s1_hi;
            MODE_RANGE:  w_count = w_lo_lt_hi ? (r_s1_hi - {1'b0, r_s1_lo}) : '0;
            MODE_WRAP:   w_count = w_lo_lt_hi ? (r_s1_hi - {1'b0, r_s1_lo})
                                             : (W'(M) - {1'b0, r_s1_lo} + r_s1_hi);
            MODE_ALL:    w_count = W'(M);
            default:     w_count = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_count <= '0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_s2_count <= w_count;
        end
    end

    assign out_count = r_s2_count;
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_range_mask_gen.sv
// Self-checking bench for range_mask_gen at N=4 (M=16).
module tb_range_mask_gen;

    localparam int unsigned N = 4;
    localparam int unsigned M = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_lo = '0;
    logic [N:0]    in_hi = '0;
    logic [1:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [M-1:0]  out_mask;
    logic [N:0]    out_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    bit            m_s1 = 1'b0;
    bit            m_s2 = 1'b0;
    bit            stalled_prev = 1'b0;
    logic [M-1:0]  prev_mask = '0;
    logic [M-1:0]  sb_mask[$];
    int            sb_cnt[$];

    range_mask_gen #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [M-1:0] model_mask(int lo, int hi, int mode);
        logic [M-1:0] m;
        for (int i = 0; i < M; i++) begin
            case (mode)
                0:       m[i] = (i < hi);
                1:       m[i] = (lo <= i) && (i < hi);
                2:       m[i] = (lo < hi) ? ((lo <= i) && (i < hi)) : ((i >= lo) || (i < hi));
                default: m[i] = 1'b1;
            endcase
        end
        return m;
    endfunction

    function automatic int exp_count(int c);
`ifdef RANGE_MASK_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Cycle monitor: occupancy model, scoreboard and hold checks.
    always @(negedge clk) begin
        logic [M-1:0] em;
        bit exp_rdy;
        if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            stalled_prev = 1'b0;
            sb_mask.delete();
            sb_cnt.delete();
        end else begin
            exp_rdy = !m_s1 || !m_s2 || out_ready;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(m_s2));
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_mask.size() == 0) begin
                    check("sb_underflow", 32'(sb_mask.size()), 32'd1);
                end else begin
                    check("sb_mask", 32'(out_mask), 32'(sb_mask.pop_front()));
                    check("sb_count", 32'(out_count), 32'(exp_count(sb_cnt.pop_front())));
                end
            end
            if (stalled_prev) check("hold_mask", 32'(out_mask), 32'(prev_mask));
            stalled_prev = out_valid && !out_ready;
            prev_mask = out_mask;
            if (in_valid && in_ready) begin
                em = model_mask(int'(in_lo), int'(in_hi), int'(in_mode));
                sb_mask.push_back(em);
                sb_cnt.push_back($countones(em));
            end
            if (!m_s2 || out_ready) m_s2 = m_s1;
            if (exp_rdy) m_s1 = in_valid;
        end
    end

    // Single request through an empty pipeline; checks two-edge latency.
    task automatic send_check(input string tag, input int lo, input int hi, input int mode,
                              input logic [M-1:0] em, input int ec);
        in_lo = N'(lo);
        in_hi = (N+1)'(hi);
        in_mode = 2'(mode);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_mask"}, 32'(out_mask), 32'(em));
        check({tag, "_cnt"}, 32'(out_count), 32'(exp_count(ec)));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int lo4[8] = '{1, 0, 3, 12, 7, 0, 15, 4};
    int hi4[8] = '{5, 16, 9, 3, 7, 0, 16, 4};
    int md4[8] = '{0, 0, 1, 2, 2, 1, 1, 3};

    initial begin
        int sent;
        int base;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_mask", 32'(out_mask), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed mode vectors
        send_check("thermo5",  0,  5, 0, 16'h001F, 5);
        send_check("thermo16", 3, 16, 0, 16'hFFFF, 16);
        send_check("thermo0",  7,  0, 0, 16'h0000, 0);
        send_check("range3_9", 3,  9, 1, 16'h01F8, 6);
        send_check("range9_3", 9,  3, 1, 16'h0000, 0);
        send_check("wrap12_3", 12, 3, 2, 16'hF007, 7);
        send_check("wrap5_5",  5,  5, 2, 16'hFFFF, 16);
        send_check("wrap2_10", 2, 10, 2, 16'h03FC, 8);
        send_check("all",      7,  2, 3, 16'hFFFF, 16);

        // Back-to-back with consumer stall in cycles 3..6
        base = n_out;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 8);
            if (sent < 8) begin
                in_lo = N'(lo4[sent]);
                in_hi = (N+1)'(hi4[sent]);
                in_mode = 2'(md4[sent]);
            end
            out_ready = !(c >= 3 && c <= 6);
            #3;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("b2b_outs", 32'(n_out - base), 32'd8);
        check("b2b_sb_empty", 32'(sb_mask.size()), 32'd0);

        // Reset with both stages full while stalled
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_lo = N'(k);
            in_hi = 5'd10;
            in_mode = 2'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_mask", 32'(out_mask), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        base = n_out;
        idle(4);
        check("postrst_none", 32'(n_out - base), 32'd0);
        send_check("postrst_req", 4, 12, 1, 16'h0FF0, 8);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(1, 0));
            in_lo = N'($urandom_range(15, 0));
            in_hi = (N+1)'($urandom_range(16, 0));
            in_mode = 2'($urandom_range(3, 0));
            out_ready = ($urandom_range(3, 0) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("rand_drain", 32'(sb_mask.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
